// File: rtl/amstrad_asic_unlock.sv
// amstrad_asic_unlock
// Snoops CPU I/O writes on the CRTC select port for the Plus ASIC unlock
// byte sequence. Once the ASIC is unlocked, RMR2 writes on the Gate Array
// port are decoded and held. The outputs feed the MMU's Plus-mode mapping
// inputs directly.
// Optional build macro: ASIC_RELOCK_EN -- when defined, a wrong final byte
// after a fully matched sequence re-locks the ASIC and clears RMR2.
// When it is undefined, the unlock stays in force until reset or until
// plus_mode drops.
module amstrad_asic_unlock (
  input  logic        CLK,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic        io_WR,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  output logic        asic_enabled,
  output logic [7:0]  rmr2,
  output logic [4:0]  seq_pos
);

  // FSM encoding doubles as the debug position: SEQk lives at k+2.
  localparam logic [4:0] ST_IDLE  = 5'd0;
  localparam logic [4:0] ST_SYNC  = 5'd1;
  localparam logic [4:0] ST_SEQ0  = 5'd2;
  localparam logic [4:0] ST_SEQ14 = 5'd16;

  localparam logic [7:0] FINAL_BYTE = 8'hEE;

  // Unlock table entry k (k = 0..13).
  function automatic logic [7:0] unlock_byte(input logic [3:0] idx);
    logic [7:0] val;
    case (idx)
      4'd0:    val = 8'hFF;
      4'd1:    val = 8'h77;
      4'd2:    val = 8'hB3;
      4'd3:    val = 8'h51;
      4'd4:    val = 8'hA8;
      4'd5:    val = 8'hD4;
      4'd6:    val = 8'h62;
      4'd7:    val = 8'h39;
      4'd8:    val = 8'h9C;
      4'd9:    val = 8'h46;
      4'd10:   val = 8'h2B;
      4'd11:   val = 8'h15;
      4'd12:   val = 8'h8A;
      4'd13:   val = 8'hCD;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  logic       old_wr_r;
  logic [4:0] state_r;
  logic       asic_r;
  logic [7:0] rmr2_r;

  logic       wr_edge_s;
  logic       crtc_hit_s;
  logic       ga_hit_s;
  logic       crtc_wr_s;
  logic       rmr2_wr_s;
  logic [3:0] seq_idx_s;
  logic       data_zero_s;
  logic [4:0] next_state_s;
  logic       unlock_evt_s;
  logic       lock_evt_s;
  logic       unused_addr_bits;

  // Only the address bits used by the two port decodes matter here.
  assign unused_addr_bits = ^{A[13:10], A[7:0]};

  assign wr_edge_s   = ~old_wr_r & io_WR;
  assign crtc_hit_s  = ~A[14] & (A[9:8] == 2'b00);
  assign ga_hit_s    = ~A[15] & A[14];
  assign crtc_wr_s   = wr_edge_s & crtc_hit_s;
  // asic_r is the pre-edge value, so an unlock and an RMR2 write can never
  // take effect on the same edge.
  assign rmr2_wr_s   = wr_edge_s & ga_hit_s & asic_r & (D[7:5] == 3'b101);
  assign seq_idx_s   = state_r[3:0] - 4'd2;
  assign data_zero_s = (D == 8'h00);

  // Next unlock-FSM state plus the unlock and lock events on a CRTC write.
  always_comb begin
    next_state_s = state_r;
    unlock_evt_s = 1'b0;
    lock_evt_s   = 1'b0;
    if (crtc_wr_s) begin
      case (state_r)
        ST_IDLE: begin
          if (data_zero_s) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (data_zero_s) begin
            next_state_s = ST_SEQ0;
          end else begin
            next_state_s = ST_SYNC;
          end
        end
        ST_SEQ14: begin
          if (D == FINAL_BYTE) begin
            unlock_evt_s = 1'b1;
            next_state_s = ST_SYNC;
          end else begin
            lock_evt_s   = 1'b1;
            next_state_s = data_zero_s ? ST_SEQ0 : ST_SYNC;
          end
        end
        default: begin
          if ((state_r >= ST_SEQ0) && (state_r < ST_SEQ14)) begin
            if (D == unlock_byte(seq_idx_s)) begin
              next_state_s = state_r + 5'd1;
            end else begin
              next_state_s = data_zero_s ? ST_SEQ0 : ST_SYNC;
            end
          end else begin
            // Unreachable encodings recover to IDLE.
            next_state_s = ST_IDLE;
          end
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Write-edge history, FSM state, unlock flag and RMR2 register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      old_wr_r <= 1'b0;
      state_r  <= ST_IDLE;
      asic_r   <= 1'b0;
      rmr2_r   <= 8'h00;
    end else if (!plus_mode) begin
      old_wr_r <= io_WR;
      state_r  <= ST_IDLE;
      asic_r   <= 1'b0;
      rmr2_r   <= 8'h00;
    end else begin
      old_wr_r <= io_WR;
      state_r  <= next_state_s;
      if (unlock_evt_s) begin
        asic_r <= 1'b1;
      end
`ifdef ASIC_RELOCK_EN
      if (lock_evt_s) begin
        asic_r <= 1'b0;
        rmr2_r <= 8'h00;
      end else if (rmr2_wr_s) begin
        rmr2_r <= {3'b000, D[4:0]};
      end
`else
      if (rmr2_wr_s) begin
        rmr2_r <= {3'b000, D[4:0]};
      end
`endif
    end
  end

`ifndef ASIC_RELOCK_EN
  logic unused_lock_evt;
  assign unused_lock_evt = lock_evt_s;
`endif

  assign asic_enabled = asic_r;
  assign rmr2         = rmr2_r;
  assign seq_pos      = state_r;

endmodule
